// File: rtl/seq_div_16x8_pkg.sv
// seq_div_16x8 shared types and constants.
// Imported by the divider top, step and interface.
package seq_div_16x8_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    localparam int BIT_DEF = 8;

    function automatic int cnt_width(input int b);
        return $clog2(b + 1);
    endfunction

    localparam int CNT_W = cnt_width(BIT_DEF);

endpackage

// File: rtl/seq_div_16x8_if.sv
// Operand/result handshake bundle for the divider.
// master = requester/consumer, slave = divider.
interface seq_div_16x8_if #(
    parameter int BIT = 8
);

    logic               in_valid;
    logic               in_ready;
    logic [2*BIT-1:0]   dividend;
    logic [BIT-1:0]     divisor;
    logic               out_valid;
    logic               out_ready;
    logic [BIT-1:0]     quotient;
    logic [BIT-1:0]     remainder;
    logic               div_zero;
    logic               overflow;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder,
        input  div_zero, overflow
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder,
        output div_zero, overflow
    );

endinterface

// File: rtl/seq_div_16x8_div_step.sv
// One restoring-division iteration: shift in a bit,
// trial-subtract, restore on borrow.
module seq_div_16x8_div_step #(
    parameter int BIT = 8
) (
    input  logic [BIT:0]   r,
    input  logic           bit_in,
    input  logic [BIT-1:0] divisor,
    output logic [BIT:0]   r_next,
    output logic           q_bit
);

    logic [BIT:0] shifted;
    logic [BIT:0] diff;
    logic         borrow;
    logic         no_sub;

    assign shifted = {r[BIT-1:0], bit_in};
    assign {borrow, diff} = {1'b0, shifted} - {2'b0, divisor};

    // r[BIT] set would mean the true shifted value exceeds any divisor
    assign no_sub = borrow & ~r[BIT];

    assign q_bit  = ~no_sub;
    assign r_next = no_sub ? shifted : diff;

endmodule

// File: rtl/seq_div_16x8.sv
// Iterative radix-2 restoring divider, 2*BIT / BIT,
// one quotient bit per clock with valid/ready on both sides.
module seq_div_16x8
    import seq_div_16x8_pkg::*;
#(
    parameter int BIT = BIT_DEF
) (
    input logic           clk,
    input logic           rst_n,
    seq_div_16x8_if.slave bus
);

    localparam int CW = cnt_width(BIT);
    localparam logic [CW-1:0] LAST = CW'(BIT - 1);

    state_t         state;
    state_t         state_n;
    logic [CW-1:0]  cnt;
    logic [BIT:0]   r;
    logic [BIT:0]   r_next;
    logic           q_bit;
    logic [BIT-1:0] lo;
    logic [BIT-1:0] dvs;
    logic [BIT-1:0] quotient;
    logic [BIT-1:0] remainder;
    logic           div_zero;
    logic           overflow;

    logic           accept;
    logic           in_dz;
    logic           in_ov;
    logic           last;

    assign accept = bus.in_valid && (state == IDLE);
    assign in_dz  = (bus.divisor == '0);
    assign in_ov  = !in_dz &&
                    (bus.dividend[2*BIT-1:BIT] >= bus.divisor);
    assign last   = (cnt == LAST);

    seq_div_16x8_div_step #(
        .BIT (BIT)
    ) u_step (
        .r       (r),
        .bit_in  (lo[BIT-1]),
        .divisor (dvs),
        .r_next  (r_next),
        .q_bit   (q_bit)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_n = (in_dz || in_ov) ? DONE : CALC;
                end
            end
            CALC: begin
                if (last) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt       <= '0;
            r         <= '0;
            lo        <= '0;
            dvs       <= '0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        dvs <= bus.divisor;
                        lo  <= bus.dividend[BIT-1:0];
                        cnt <= '0;
                        unique case (1'b1)
                            in_dz: begin
                                div_zero  <= 1'b1;
                                overflow  <= 1'b0;
                                quotient  <= '1;
                                remainder <= bus.dividend[BIT-1:0];
                            end
                            in_ov: begin
                                div_zero  <= 1'b0;
                                overflow  <= 1'b1;
                                quotient  <= '1;
                                remainder <= '1;
                            end
                            default: begin
                                div_zero <= 1'b0;
                                overflow <= 1'b0;
                                quotient <= '0;
                                r <= {1'b0, bus.dividend[2*BIT-1:BIT]};
                            end
                        endcase
                    end
                end
                CALC: begin
                    r        <= r_next;
                    lo       <= {lo[BIT-2:0], 1'b0};
                    quotient <= {quotient[BIT-2:0], q_bit};
                    cnt      <= cnt + 1'b1;
                    if (last) begin
                        remainder <= r_next[BIT-1:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.quotient  = quotient;
    assign bus.remainder = remainder;
    assign bus.div_zero  = div_zero;
    assign bus.overflow  = overflow;

endmodule
